// File: rtl/seq_divider.sv
// seq_divider: sequential non-restoring integer divider, one quotient bit per cycle.
//   clk, rst (async active-low)
//   in_valid/in_ready, dividend, divisor, div_signed : request handshake and operands
//   abort      : drops the operation in flight
//   out_valid/out_ready, q, r, div_zero, ovf         : result handshake and result
//   busy       : high whenever not idle
module seq_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             div_signed,
    input  logic             abort,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] r,
    output logic             div_zero,
    output logic             ovf,
    output logic             busy
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t           state, state_nx;
    logic [WIDTH:0]   rem;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] dvs;
    logic [CW-1:0]    cnt;
    logic             neg_q;
    logic             neg_r;

    logic             accept;
    logic             zero_div;
    logic             min_ovf;
    logic [WIDTH-1:0] min_val;
    logic [WIDTH-1:0] dd_abs;
    logic [WIDTH-1:0] dv_abs;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH:0]   rem_step;
    logic [WIDTH-1:0] r_mag;

    assign in_ready  = state == IDLE;
    assign out_valid = state == DONE;
    assign busy      = state != IDLE;
    assign accept    = in_valid && in_ready;
    assign min_val   = {1'b1, {(WIDTH-1){1'b0}}};
    assign zero_div  = divisor == '0;
    assign min_ovf   = div_signed && dividend == min_val && divisor == '1;
    assign dd_abs    = (div_signed && dividend[WIDTH-1]) ? -dividend : dividend;
    assign dv_abs    = (div_signed && divisor[WIDTH-1]) ? -divisor : divisor;

    // The partial remainder is kept in WIDTH+1 bits; intermediate wrap is harmless
    // because every step result lies in [-divisor, divisor).
    assign rem_sh    = {rem[WIDTH-1:0], quo[WIDTH-1]};
    assign rem_step  = rem[WIDTH] ? rem_sh + {1'b0, dvs} : rem_sh - {1'b0, dvs};
    assign r_mag     = rem[WIDTH] ? rem[WIDTH-1:0] + dvs : rem[WIDTH-1:0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = accept ? ((zero_div || min_ovf) ? DONE : CALC) : IDLE;
            CALC:    state_nx = abort ? IDLE : (cnt == CW'(WIDTH-1)) ? FIX : CALC;
            FIX:     state_nx = abort ? IDLE : DONE;
            default: state_nx = (abort || out_ready) ? IDLE : DONE;
        endcase
    end

    // Result registers only change when a result is about to be presented,
    // so they hold their previous values while out_valid is low.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rem      <= '0;
            quo      <= '0;
            dvs      <= '0;
            cnt      <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            q        <= '0;
            r        <= '0;
            div_zero <= 1'b0;
            ovf      <= 1'b0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    rem   <= '0;
                    cnt   <= '0;
                    quo   <= dd_abs;
                    dvs   <= dv_abs;
                    neg_q <= div_signed && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                    neg_r <= div_signed && dividend[WIDTH-1];
                    if (zero_div) begin
                        q        <= '1;
                        r        <= dividend;
                        div_zero <= 1'b1;
                        ovf      <= 1'b0;
                    end else if (min_ovf) begin
                        q        <= dividend;
                        r        <= '0;
                        div_zero <= 1'b0;
                        ovf      <= 1'b1;
                    end
                end
                CALC: begin
                    rem <= rem_step;
                    quo <= {quo[WIDTH-2:0], ~rem_step[WIDTH]};
                    cnt <= cnt + 1'b1;
                end
                FIX: if (!abort) begin
                    q        <= neg_q ? -quo : quo;
                    r        <= neg_r ? -r_mag : r_mag;
                    div_zero <= 1'b0;
                    ovf      <= 1'b0;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: directed self-checking bench for seq_divider at WIDTH=32 and WIDTH=8.
module tb_seq_divider;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0, in_ready, div_signed = 1'b0, abort = 1'b0;
    logic        out_valid, out_ready = 1'b0, div_zero, ovf, busy;
    logic [31:0] dividend = '0, divisor = '0, q, r;
    logic        v8 = 1'b0, rdy8, s8 = 1'b0, ov8_valid, ord8 = 1'b0, dz8, ovf8, busy8;
    logic [7:0]  a8 = '0, b8 = '0, q8, r8;
    int          errors = 0;
    int          checks = 0;

    always #5 clk = ~clk;

    seq_divider #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .dividend(dividend), .divisor(divisor), .div_signed(div_signed), .abort(abort),
        .out_valid(out_valid), .out_ready(out_ready), .q(q), .r(r),
        .div_zero(div_zero), .ovf(ovf), .busy(busy)
    );

    seq_divider #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(v8), .in_ready(rdy8),
        .dividend(a8), .divisor(b8), .div_signed(s8), .abort(1'b0),
        .out_valid(ov8_valid), .out_ready(ord8), .q(q8), .r(r8),
        .div_zero(dz8), .ovf(ovf8), .busy(busy8)
    );

    task automatic start(input logic [31:0] a, input logic [31:0] b, input logic s);
        @(negedge clk);
        dividend = a; divisor = b; div_signed = s; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // n = edges from the accept edge (0) to the first edge that samples out_valid high
    task automatic wait_done(output int n);
        n = 1;
        while (!out_valid && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic consume();
        @(negedge clk); out_ready = 1'b1;
        @(posedge clk); #1; out_ready = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got %b want 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b want 0", out_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", busy); end
        checks++; if ({q, r} !== 64'd0) begin errors++; $display("FAIL rst_qr got %h %h want 0 0", q, r); end
        checks++; if ({div_zero, ovf} !== 2'b00) begin errors++; $display("FAIL rst_flags got %b%b want 00", div_zero, ovf); end
        @(negedge clk); rst = 1'b1;
    endtask

    task automatic test_unsigned();
        int n;
        start(32'd100, 32'd7, 1'b0);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL u_busy got %b want 1", busy); end
        wait_done(n);
        checks++; if (n !== 34) begin errors++; $display("FAIL u_latency got %0d want 34", n); end
        checks++; if (q !== 32'd14) begin errors++; $display("FAIL u_q got %h want %h", q, 32'd14); end
        checks++; if (r !== 32'd2) begin errors++; $display("FAIL u_r got %h want %h", r, 32'd2); end
        checks++; if ({div_zero, ovf} !== 2'b00) begin errors++; $display("FAIL u_flags got %b%b want 00", div_zero, ovf); end
        consume();
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL u_idle got %b want 1", in_ready); end
        start(32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        wait_done(n);
        checks++; if (n !== 34) begin errors++; $display("FAIL u_min_latency got %0d want 34", n); end
        checks++; if ({q, r} !== {32'd0, 32'h8000_0000}) begin errors++; $display("FAIL u_min_qr got %h %h want 0 80000000", q, r); end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL u_min_ovf got %b want 0", ovf); end
        consume();
    endtask

    task automatic test_signed();
        int n;
        start(32'hFFFF_FFF9, 32'd2, 1'b1);
        wait_done(n);
        checks++; if ({q, r} !== {32'hFFFF_FFFD, 32'hFFFF_FFFF}) begin errors++; $display("FAIL s_m7_2 got %h %h want fffffffd ffffffff", q, r); end
        consume();
        start(32'd7, 32'hFFFF_FFFE, 1'b1);
        wait_done(n);
        checks++; if ({q, r} !== {32'hFFFF_FFFD, 32'd1}) begin errors++; $display("FAIL s_7_m2 got %h %h want fffffffd 1", q, r); end
        consume();
        start(32'hFFFF_FFF0, 32'hFFFF_FFFD, 1'b1);
        wait_done(n);
        checks++; if ({q, r} !== {32'd5, 32'hFFFF_FFFF}) begin errors++; $display("FAIL s_m16_m3 got %h %h want 5 ffffffff", q, r); end
        consume();
    endtask

    task automatic test_div_zero();
        int n;
        start(32'd5, 32'd0, 1'b0);
        wait_done(n);
        checks++; if (n !== 1) begin errors++; $display("FAIL dz_latency got %0d want 1", n); end
        checks++; if ({q, r} !== {32'hFFFF_FFFF, 32'd5}) begin errors++; $display("FAIL dz_qr got %h %h want ffffffff 5", q, r); end
        checks++; if ({div_zero, ovf} !== 2'b10) begin errors++; $display("FAIL dz_flags got %b%b want 10", div_zero, ovf); end
        consume();
        start(32'hFFFF_FFFB, 32'd0, 1'b1);
        wait_done(n);
        checks++; if ({q, r, div_zero} !== {32'hFFFF_FFFF, 32'hFFFF_FFFB, 1'b1}) begin errors++; $display("FAIL dz_signed got %h %h %b want ffffffff fffffffb 1", q, r, div_zero); end
        consume();
    endtask

    task automatic test_ovf();
        int n;
        start(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        wait_done(n);
        checks++; if (n !== 1) begin errors++; $display("FAIL ovf_latency got %0d want 1", n); end
        checks++; if ({q, r} !== {32'h8000_0000, 32'd0}) begin errors++; $display("FAIL ovf_qr got %h %h want 80000000 0", q, r); end
        checks++; if ({div_zero, ovf} !== 2'b01) begin errors++; $display("FAIL ovf_flags got %b%b want 01", div_zero, ovf); end
        consume();
    endtask

    task automatic test_hold();
        int n;
        start(32'd1000, 32'd3, 1'b0);
        wait_done(n);
        for (int i = 0; i < 10; i++) begin
            checks++; if ({out_valid, in_ready, q, r} !== {1'b1, 1'b0, 32'd333, 32'd1}) begin errors++; $display("FAIL hold_%0d got v=%b rdy=%b %h %h want 1 0 14d 1", i, out_valid, in_ready, q, r); end
            @(posedge clk); #1;
        end
        consume();
        checks++; if ({in_ready, out_valid} !== 2'b10) begin errors++; $display("FAIL hold_release got %b%b want 10", in_ready, out_valid); end
    endtask

    task automatic test_abort();
        int n;
        int seen;
        start(32'd100, 32'd7, 1'b0);
        repeat (9) @(posedge clk);
        @(negedge clk); abort = 1'b1;
        @(posedge clk); #1; abort = 1'b0;
        checks++; if ({in_ready, busy} !== 2'b10) begin errors++; $display("FAIL abort_idle got %b%b want 10", in_ready, busy); end
        seen = 0;
        repeat (40) begin @(posedge clk); #1; if (out_valid) seen++; end
        checks++; if (seen !== 0) begin errors++; $display("FAIL abort_no_valid got %0d want 0", seen); end
        start(32'hFFFF_FFFF, 32'h10, 1'b0);
        wait_done(n);
        checks++; if ({q, r} !== {32'h0FFF_FFFF, 32'hF}) begin errors++; $display("FAIL abort_next got %h %h want 0fffffff f", q, r); end
        @(negedge clk); abort = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1; abort = 1'b0; out_ready = 1'b0;
        checks++; if ({out_valid, in_ready, q} !== {1'b0, 1'b1, 32'h0FFF_FFFF}) begin errors++; $display("FAIL abort_done got v=%b rdy=%b q=%h want 0 1 0fffffff", out_valid, in_ready, q); end
    endtask

    task automatic test_rst_mid();
        int seen;
        start(32'd100, 32'd7, 1'b0);
        repeat (5) @(posedge clk);
        @(negedge clk); rst = 1'b0;
        #1;
        checks++; if ({in_ready, out_valid, busy, div_zero, ovf} !== 5'b10000) begin errors++; $display("FAIL rmid_ctl got %b%b%b%b%b want 10000", in_ready, out_valid, busy, div_zero, ovf); end
        checks++; if ({q, r} !== 64'd0) begin errors++; $display("FAIL rmid_qr got %h %h want 0 0", q, r); end
        @(negedge clk); rst = 1'b1;
        seen = 0;
        repeat (40) begin @(posedge clk); #1; if (out_valid) seen++; end
        checks++; if (seen !== 0) begin errors++; $display("FAIL rmid_no_valid got %0d want 0", seen); end
    endtask

    task automatic test_width8();
        int n;
        @(negedge clk); a8 = 8'h80; b8 = 8'h03; s8 = 1'b1; v8 = 1'b1;
        @(posedge clk); #1; v8 = 1'b0;
        n = 1;
        while (!ov8_valid && n < 100) begin @(posedge clk); #1; n++; end
        checks++; if (n !== 10) begin errors++; $display("FAIL w8_latency got %0d want 10", n); end
        checks++; if ({q8, r8} !== {8'hD6, 8'hFE}) begin errors++; $display("FAIL w8_qr got %h %h want d6 fe", q8, r8); end
        @(negedge clk); ord8 = 1'b1;
        @(posedge clk); #1; ord8 = 1'b0;
        @(negedge clk); a8 = 8'h80; b8 = 8'hFF; s8 = 1'b1; v8 = 1'b1;
        @(posedge clk); #1; v8 = 1'b0;
        checks++; if ({ov8_valid, ovf8, q8, r8} !== {1'b1, 1'b1, 8'h80, 8'h00}) begin errors++; $display("FAIL w8_ovf got v=%b o=%b %h %h want 1 1 80 00", ov8_valid, ovf8, q8, r8); end
        @(negedge clk); ord8 = 1'b1;
        @(posedge clk); #1; ord8 = 1'b0;
    endtask

    initial begin
        test_reset();
        test_unsigned();
        test_signed();
        test_div_zero();
        test_ovf();
        test_hold();
        test_abort();
        test_rst_mid();
        test_width8();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
